// File: rtl/arcfour_pkg.sv
// rtl/arcfour_pkg.sv - shared types and constants for the parallel RC4 key-search top level
//
// Purpose: state types for the key search and for the plaintext readout stage,
//          plus the byte order used when the winning key is streamed out.
// Ports:   none (package).

package arcfour_pkg;

    // Overall key-search progress, as seen by the top level.
    typedef enum logic [1:0] {
        SEARCH_IDLE,
        SEARCH_RUN,
        SEARCH_SUCCESS,
        SEARCH_FAIL
    } search_state_t;

    // Readout stage states.
    typedef enum logic [2:0] {
        DUMP_IDLE,
        DUMP_KEY,
        DUMP_RD_ISSUE,
        DUMP_RD_WAIT,
        DUMP_SEND,
        DUMP_DONE
    } dump_state_t;

    // Key bytes leave the readout stage most-significant byte first.
    localparam bit KEY_MSB_FIRST = 1'b1;

endpackage : arcfour_pkg

// File: rtl/plaintext_dump.sv
// rtl/plaintext_dump.sv - streams the winning key and decrypted message out as bytes
//
// Purpose: after a successful search, latch the winning core index and key, then
//          emit KEY_LENGTH key bytes followed by MESSAGE_LENGTH plaintext bytes read
//          from that core's message RAM over a valid/ready byte stream.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start, abort     one-cycle pulses: begin a dump (IDLE only) / return to IDLE
//   core_sel, key    winning core index and key, sampled on an accepted start
//   rd_core          latched core index, selects the message RAM at the top level
//   a_addr, a_q      message RAM read address / data (one-cycle read latency)
//   out_data,
//   out_valid,
//   out_ready        byte stream towards the UART/display sink
//   busy, done       dump in progress / one-cycle completion pulse

module plaintext_dump
    import arcfour_pkg::*;
#(
    parameter int NUM_CORES          = 90,
    parameter int LOG_NUM_CORES      = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int RAM_WIDTH          = 8,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [LOG_NUM_CORES-1:0]         core_sel,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
    output logic [LOG_NUM_CORES-1:0]         rd_core,
    output logic [MESSAGE_LOG_LENGTH-1:0]    a_addr,
    input  logic [RAM_WIDTH-1:0]             a_q,
    output logic [RAM_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;
    // One spare bit so MESSAGE_LENGTH == 2**MESSAGE_LOG_LENGTH still reaches its last index.
    localparam int CNT_W = MESSAGE_LOG_LENGTH + 1;

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_LENGTH - 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MESSAGE_LENGTH - 1);

    if (NUM_CORES > (2 ** LOG_NUM_CORES)) begin : g_core_width_check
        $error("plaintext_dump: LOG_NUM_CORES too narrow for NUM_CORES");
    end

    dump_state_t                   state_q,     state_d;
    logic [LOG_NUM_CORES-1:0]      rd_core_q,   rd_core_d;
    logic [MESSAGE_LOG_LENGTH-1:0] a_addr_q,    a_addr_d;
    logic [CNT_W-1:0]              cnt_q,       cnt_d;
    logic [KEY_W-1:0]              key_sh_q,    key_sh_d;
    logic [RAM_WIDTH-1:0]          out_data_q,  out_data_d;
    logic                          out_valid_q, out_valid_d;

    logic xfer;
    assign xfer = out_valid_q && out_ready;

    // Byte of the key shift register that goes out next.
    function automatic logic [RAM_WIDTH-1:0] key_head(input logic [KEY_W-1:0] k);
        if (KEY_MSB_FIRST) return k[KEY_W-1 -: RAM_WIDTH];
        else               return k[RAM_WIDTH-1:0];
    endfunction

    // Key shift register after the head byte has been taken.
    function automatic logic [KEY_W-1:0] key_advance(input logic [KEY_W-1:0] k);
        if (KEY_MSB_FIRST) return k << RAM_WIDTH;
        else               return k >> RAM_WIDTH;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DUMP_IDLE;
            rd_core_q   <= '0;
            a_addr_q    <= '0;
            cnt_q       <= '0;
            key_sh_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_core_q   <= rd_core_d;
            a_addr_q    <= a_addr_d;
            cnt_q       <= cnt_d;
            key_sh_q    <= key_sh_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = DUMP_IDLE;
        end else begin
            unique case (state_q)
                DUMP_IDLE:     if (start) state_d = DUMP_KEY;
                DUMP_KEY:      if (xfer && cnt_q == KEY_LAST) state_d = DUMP_RD_ISSUE;
                DUMP_RD_ISSUE: state_d = DUMP_RD_WAIT;
                DUMP_RD_WAIT:  state_d = DUMP_SEND;
                DUMP_SEND: begin
                    if (xfer) state_d = (cnt_q == MSG_LAST) ? DUMP_DONE : DUMP_RD_ISSUE;
                end
                DUMP_DONE:     state_d = DUMP_IDLE;
                default:       state_d = DUMP_IDLE;
            endcase
        end
    end

    // Datapath: counter, read address, key shifter and output register.
    always_comb begin
        rd_core_d   = rd_core_q;
        a_addr_d    = a_addr_q;
        cnt_d       = cnt_q;
        key_sh_d    = key_sh_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (abort) begin
            // rd_core and a_addr deliberately keep their values.
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                DUMP_IDLE: begin
                    if (start) begin
                        rd_core_d   = core_sel;
                        a_addr_d    = '0;
                        cnt_d       = '0;
                        out_data_d  = key_head(key);
                        key_sh_d    = key_advance(key);
                        out_valid_d = 1'b1;
                    end
                end
                DUMP_KEY: begin
                    if (xfer) begin
                        if (cnt_q == KEY_LAST) begin
                            // Counter is reused as the message byte index from here on.
                            cnt_d       = '0;
                            out_valid_d = 1'b0;
                        end else begin
                            cnt_d      = cnt_q + CNT_W'(1);
                            out_data_d = key_head(key_sh_q);
                            key_sh_d   = key_advance(key_sh_q);
                        end
                    end
                end
                DUMP_RD_WAIT: begin
                    // a_addr was presented at the RD_ISSUE exit edge, so a_q is valid now.
                    out_data_d  = a_q;
                    out_valid_d = 1'b1;
                end
                DUMP_SEND: begin
                    if (xfer) begin
                        out_valid_d = 1'b0;
                        if (cnt_q != MSG_LAST) begin
                            cnt_d    = cnt_q + CNT_W'(1);
                            a_addr_d = a_addr_q + MESSAGE_LOG_LENGTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q != DUMP_IDLE);
        done = (state_q == DUMP_DONE);
    end

    assign rd_core   = rd_core_q;
    assign a_addr    = a_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule : plaintext_dump

// File: tb/tb_plaintext_dump.sv
// tb/tb_plaintext_dump.sv - self-checking bench for plaintext_dump

module tb_plaintext_dump;

    localparam int KEY_LENGTH = 3;
    localparam int MSG_LEN    = 32;
    localparam int BUDGET     = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  core_sel = '0;
    logic [23:0] key = '0;
    logic [7:0]  rd_core;
    logic [4:0]  a_addr;
    logic [7:0]  a_q = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    logic [7:0] mem [MSG_LEN];
    logic [7:0] exp_q [$];

    plaintext_dump #(
        .NUM_CORES(90), .LOG_NUM_CORES(8), .KEY_LENGTH(KEY_LENGTH),
        .RAM_WIDTH(8), .MESSAGE_LENGTH(MSG_LEN), .MESSAGE_LOG_LENGTH(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .core_sel(core_sel), .key(key), .rd_core(rd_core), .a_addr(a_addr),
        .a_q(a_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Top-level RAM mux model: only core 7 holds the message.
    always @(posedge clk) a_q <= (rd_core == 8'd7) ? mem[a_addr] : 8'hEE;

    // Full dump with scoreboard; optional random ready, injected start, abort at message byte.
    task automatic run_dump(input logic [23:0] k, input bit rnd, input int inject_at,
                            input int abort_at, output int nbytes, output int ndone,
                            output int last_edge, output int done_edge);
        bit stalled = 0;
        bit finished = 0;
        logic [7:0] held = '0;
        logic [7:0] exp;
        int rel;
        nbytes = 0; ndone = 0; last_edge = -1; done_edge = -1;
        @(negedge clk);
        start = 1'b1; core_sel = 8'd7; key = k; out_ready = 1'b1;
        e0 = cyc + 1;
        exp_q.push_back(k[23:16]); exp_q.push_back(k[15:8]); exp_q.push_back(k[7:0]);
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(mem[i]);
        for (int t = 0; t < BUDGET; t++) begin
            @(negedge clk);
            rel = cyc - e0;
            start = 1'b0; core_sel = '0; key = '0;
            if (rel == inject_at) begin
                start = 1'b1; core_sel = 8'd3; key = 24'h123456;
            end
            if (rel == 0) begin
                checks++;
                if (busy !== 1'b1 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_cycle: busy=%b out_valid=%b required 1 1", busy, out_valid);
                end
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h required 1 %h", out_valid, out_data, held);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                done_edge = rel;
            end
            if (ndone > 0 && busy === 1'b0) begin
                finished = 1;
                break;
            end
            if (abort_at >= 0 && nbytes == KEY_LENGTH + abort_at && out_valid === 1'b1) begin
                out_ready = 1'b0;
                abort = 1'b1;
                finished = 1;
                break;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte: got %h required none", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL byte_%0d: got %h required %h", nbytes, out_data, exp);
                    end
                end
                nbytes++;
                last_edge = rel + 1;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held = out_data;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL dump_timeout: finished=0 required 1");
        end
        start = 1'b0; core_sel = '0; key = '0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || a_addr !== 5'd0 ||
            rd_core !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b data=%h addr=%0d core=%0d busy=%b done=%b required all 0",
                     out_valid, out_data, a_addr, rd_core, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int nb, nd, le, de;
        run_dump(24'h0003FF, 0, -1, -1, nb, nd, le, de);
        checks++;
        if (nb != 35) begin errors++; $display("FAIL nominal_count: got %0d required 35", nb); end
        checks++;
        if (le != 99) begin errors++; $display("FAIL nominal_last_edge: got %0d required 99", le); end
        checks++;
        if (nd != 1 || de != 99) begin
            errors++; $display("FAIL nominal_done: count=%0d at=%0d required 1 at 99", nd, de);
        end
        checks++;
        if (rd_core !== 8'd7) begin errors++; $display("FAIL nominal_rd_core: got %0d required 7", rd_core); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL nominal_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int nb, nd, le, de;
        run_dump(24'hA55AC3, 1, -1, -1, nb, nd, le, de);
        checks++;
        if (nb != 35 || nd != 1) begin
            errors++; $display("FAIL bp_counts: bytes=%0d done=%0d required 35 1", nb, nd);
        end
        checks++;
        if (le < 99) begin errors++; $display("FAIL bp_last_edge: got %0d required >= 99", le); end
    endtask

    task automatic test_ignored_start();
        int nb, nd, le, de;
        run_dump(24'h0003FF, 0, 20, -1, nb, nd, le, de);
        checks++;
        if (nb != 35 || nd != 1 || le != 99) begin
            errors++; $display("FAIL ign_counts: bytes=%0d done=%0d last=%0d required 35 1 99", nb, nd, le);
        end
        checks++;
        if (rd_core !== 8'd7) begin errors++; $display("FAIL ign_rd_core: got %0d required 7", rd_core); end
    endtask

    task automatic test_abort();
        int nb, nd, le, de;
        bit saw_done = 0;
        run_dump(24'h0003FF, 0, -1, 10, nb, nd, le, de);
        checks++;
        if (nb != 13) begin errors++; $display("FAIL abort_point: got %0d required 13", nb); end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b required 0 0 0", out_valid, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done: got done pulse required none"); end
        exp_q.delete();
        run_dump(24'h112233, 0, -1, -1, nb, nd, le, de);
        checks++;
        if (nb != 35 || nd != 1) begin
            errors++; $display("FAIL abort_redump: bytes=%0d done=%0d required 35 1", nb, nd);
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; core_sel = 8'd3; key = 24'hFFFFFF;
        @(negedge clk);
        start = 1'b0; abort = 1'b0; core_sel = '0; key = '0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || rd_core !== 8'd7) begin
            errors++;
            $display("FAIL start_abort: busy=%b valid=%b core=%0d required 0 0 7", busy, out_valid, rd_core);
        end
    endtask

    task automatic test_reset_mid();
        int nb, nd, le, de;
        @(negedge clk);
        start = 1'b1; core_sel = 8'd7; key = 24'h0003FF; out_ready = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0; core_sel = '0; key = '0;
        for (int t = 0; t < 50 && cyc < e0 + 7; t++) @(negedge clk);
        // Mid-cycle after E7: RD_WAIT for message byte 1, a_addr = 1, rd_core = 7.
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || a_addr !== 5'd0 ||
            rd_core !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%h addr=%0d core=%0d busy=%b done=%b required all 0",
                     out_valid, out_data, a_addr, rd_core, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        run_dump(24'h0003FF, 0, -1, -1, nb, nd, le, de);
        checks++;
        if (nb != 35 || nd != 1 || le != 99) begin
            errors++; $display("FAIL reset_redump: bytes=%0d done=%0d last=%0d required 35 1 99", nb, nd, le);
        end
    endtask

    initial begin
        string msg;
        msg = "the quick brown fox jumps over t";
        for (int i = 0; i < MSG_LEN; i++) mem[i] = msg[i];
        test_reset();
        test_nominal();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_start_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_plaintext_dump

// File: doc/plaintext_dump.md
# plaintext_dump

Post-search readout stage for the parallel RC4 key-search top level. When the search reaches SUCCESS, it latches the winning core index and key. It then reads that core's decrypted-message RAM and streams the key bytes followed by all plaintext bytes out over a valid/ready byte interface, for the UART/display sink. One dump per start pulse; abortable when the search is restarted.

## Interface
- NUM_CORES, 90, number of search cores
- LOG_NUM_CORES, 8, width of core index
- KEY_LENGTH, 3, key bytes emitted in the header
- RAM_WIDTH, 8, byte width
- MESSAGE_LENGTH, 32, plaintext bytes to read
- MESSAGE_LOG_LENGTH, 5, message RAM address width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; forces the reset values below
- start  in  1  one-cycle pulse; honoured only in IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- core_sel  in  LOG_NUM_CORES  winning core index, sampled on accepted start
- key  in  KEY_LENGTH*RAM_WIDTH  winning key, sampled on accepted start
- rd_core  out  LOG_NUM_CORES  registered core_sel; top level muxes the A RAM read port with it
- a_addr  out  MESSAGE_LOG_LENGTH  registered message RAM read address
- a_q  in  RAM_WIDTH  message RAM read data, one-cycle latency (address captured at edge, q valid following cycle)
- out_data  out  RAM_WIDTH  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts; transfer when out_valid && out_ready at a rising edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last byte transfers

## Operation
- Reset values: state IDLE; out_valid 0, out_data 0, a_addr 0, rd_core 0, busy 0, done 0.
- States: IDLE, KEY, RD_ISSUE, RD_WAIT, SEND, DONE.
- IDLE:
  - start && !abort latches core_sel→rd_core and key.
  - Clears the byte counter and a_addr.
  - Loads out_data = key[MSB byte] and sets out_valid. Next state KEY.
- KEY: emits key bytes MSB-first, one per transfer. On the transfer of byte KEY_LENGTH-1, clears out_valid and goes to RD_ISSUE.
- RD_ISSUE: a_addr is already stable; stays one cycle; goes to RD_WAIT.
- RD_WAIT: stays one cycle. On the exit edge: out_data = a_q, out_valid = 1, go to SEND.
- SEND: holds out_valid and out_data stable until transfer. On transfer:
  - Clears out_valid.
  - If counter == MESSAGE_LENGTH-1, go to DONE.
  - Otherwise increment the counter and a_addr, go to RD_ISSUE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Byte counter width is MESSAGE_LOG_LENGTH+1, so MESSAGE_LENGTH = 2^MESSAGE_LOG_LENGTH terminates correctly. a_addr never wraps mid-dump.
- abort:
  - From any state, next edge gives IDLE with out_valid 0 and done 0. No done pulse is issued.
  - rd_core and a_addr hold their values.
  - Abort dropping out_valid without a transfer is permitted.
- start while busy is ignored. start && abort in IDLE: abort wins, stays IDLE.
- reset mid-dump: immediate IDLE and reset values; no partial done.

## Timing
- Start sampled at edge E0; first key byte has out_valid high in the cycle after E0.
- With out_ready held high:
  - Key bytes transfer at E1..E(KEY_LENGTH).
  - Message byte n transfers at E(KEY_LENGTH+3+3n).
- Defaults: byte 0 at E6, byte 31 at E99, done high in the cycle after E99, IDLE after E100. busy high from after E0 through the DONE cycle.
- Throughput: 3 cycles per plaintext byte at full ready. Each cycle of out_ready low adds one cycle in KEY/SEND only.
- a_addr is held from RD_ISSUE entry through RD_WAIT exit, so it changes only on SEND transfer edges.

## Structure
- State enum (dump_state_t) and byte-order constant belong in the shared arcfour package beside the search state type.
- No sub-module: single FSM plus counter and output register.
- The A RAM read mux across cores stays in the top level, indexed by rd_core.

## Test plan
- Nominal dump:
  - Stimulus: key 24'h0003FF, core_sel 7, RAM model holding "the quick brown fox jumps over t", out_ready high.
  - Response: bytes 00 03 FF then 74 68 65 ...; byte 31 at E99; done pulse in the cycle after E99; rd_core = 7.
- Backpressure:
  - Stimulus: out_ready toggled pseudo-randomly.
  - Response: out_data stable while out_valid && !out_ready; identical byte sequence of 35 bytes; exactly one done.
- Abort:
  - Stimulus: abort while out_valid high in SEND at byte 10.
  - Response: next cycle IDLE, out_valid 0, busy 0, no done. A later start redumps from key byte 0.
- Ignored start:
  - Stimulus: second start with core_sel 3 during a dump.
  - Response: rd_core stays 7; sequence unchanged.
- Reset mid-operation:
  - Stimulus: async reset asserted mid-cycle in RD_WAIT.
  - Response: outputs go to reset values without waiting for an edge; start after release works normally.
- Simultaneous start and abort in IDLE: remains IDLE, busy 0.
